mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between the fetch stage (IFU, read-only) and the load/store unit (LSU, read/write).
- One transaction is outstanding at a time. LSU has fixed priority, with an anti-starvation counter that guarantees IFU progress.
- A watchdog turns a missing memory acknowledge into an error response, which feeds the CSR trap path.
- Sits between the pipeline's IF/MEM stages and the memory wrapper; the pipeline stalls on the requester's pending request until the matching ack.

Parameters:
- STARVE_MAX, 3: consecutive LSU grants made while IFU is waiting before IFU is forced a grant (legal range 1..15).
- TIMEOUT, 16: cycles in a BUSY state without mem_ack before the transaction aborts with an error (legal range ≥2).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- if_req  input  1  IFU read request, held until if_ack
- if_addr  input  32  IFU word address
- if_rdata  output  32  IFU read data, valid with if_ack
- if_ack  output  1  one-cycle completion pulse to IFU
- if_err  output  1  with if_ack: transaction timed out
- ls_req  input  1  LSU request, held until ls_ack
- ls_we  input  1  1 = store, 0 = load
- ls_mask  input  4  byte enables for store
- ls_addr  input  32  LSU address
- ls_wdata  input  32  store data
- ls_rdata  output  32  load data, valid with ls_ack
- ls_ack  output  1  one-cycle completion pulse to LSU
- ls_err  output  1  with ls_ack: transaction timed out
- mem_req  output  1  memory request, high throughout a transaction
- mem_we  output  1  write strobe qualifier
- mem_mask  output  4  byte enables (4'b0000 for reads)
- mem_addr  output  32  memory address
- mem_wdata  output  32  write data
- mem_rdata  input  32  memory read data, valid with mem_ack
- mem_ack  input  1  memory completion, single-cycle pulse
- busy  output  1  high in any BUSY state

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; starve_cnt=0; timer=0.
  - All outputs 0, including the mem_* attribute registers and rdata registers.
  - mem_req drops immediately; any in-flight transaction is discarded with no ack.
- Requester contract: req and its attributes stay stable from assertion until the ack cycle. Requester may drop req in the cycle after ack.
- FSM states: IDLE, BUSY_IF, BUSY_LS.
- IDLE arbitration, evaluated each cycle:
  - A requester whose ack is high this cycle is ineligible, which prevents a double grant.
  - Only ls_req eligible → grant LSU.
  - Only if_req eligible → grant IFU.
  - Both eligible → grant IFU if starve_cnt==STARVE_MAX, else grant LSU.
- On grant:
  - Latch the granted requester's attributes into the mem_* registers. IFU grant forces mem_we=0 and mem_mask=0.
  - Next state is BUSY_IF or BUSY_LS; timer=0.
- starve_cnt:
  - +1 on an LSU grant while if_req is eligible, saturating at STARVE_MAX.
  - Cleared on any IFU grant.
  - Unchanged otherwise.
- BUSY_x:
  - mem_req=1 and busy=1; attributes held constant; timer increments each cycle.
  - mem_ack=1 → next cycle x_ack=1, x_rdata=mem_rdata (0 for stores), x_err=0; state→IDLE.
  - timer==TIMEOUT-1 with no mem_ack → next cycle x_ack=1, x_err=1, x_rdata=0; state→IDLE.
  - mem_ack and timeout in the same cycle: mem_ack wins, no error.
- mem_req deasserts in the cycle x_ack is high, so there is no bubble-free back-to-back. A new grant can be decided in that same IDLE cycle, and mem_req reasserts the following cycle.
- Latency:
  - req seen in IDLE at cycle N → mem_req at N+1.
  - mem_ack at cycle M≥N+1 → x_ack at M+1.
  - Minimum 2 cycles from req to ack.
- Ack/err/rdata validity:
  - x_ack and x_err are single-cycle pulses.
  - x_rdata holds its value until the next ack to the same requester.
  - if_ack and ls_ack are never high in the same cycle.
- mem_ack received in IDLE: ignored, no state change.
- Requester dropping req mid-BUSY (contract violation): the transaction still completes and is acked.

Test Plan:
- IFU-only: if_req=1, if_addr=0x100; mem_ack one cycle after mem_req rises, mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_we=0; if_ack=1 with if_rdata=0xDEADBEEF exactly 2 cycles after mem_req rose; busy low afterwards.
- Priority: if_req and ls_req (store, 0x200, 0xA5A5A5A5, mask 4'hF) rise together, memory acks after 3 cycles → LSU served first (mem_we=1, mem_mask=4'hF), ls_ack then IFU grant; starve_cnt=1 after first grant.
- Starvation, STARVE_MAX=3: ls_req re-asserted immediately after every ack and if_req held → exactly 3 LSU transactions, then 1 IFU transaction, then LSU resumes; starve_cnt reads 0 after the IFU grant.
- Timeout, TIMEOUT=16: ls_req load, mem_ack never asserted → ls_ack=1, ls_err=1, ls_rdata=0 on cycle 16 after mem_req rose; FSM in IDLE; a subsequent normal transaction completes with err=0.
- Ack/timeout collision: mem_ack pulsed exactly in timer==TIMEOUT-1 cycle with mem_rdata=0x12345678 → ack with err=0 and rdata=0x12345678.
- Reset mid-transaction: rst_n pulled low asynchronously during BUSY_LS → mem_req, busy and all acks 0 without waiting for a clock edge; after release, a stray mem_ack is ignored and no ack is issued to either requester.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported memory between the IFU and the LSU,
//             one transaction at a time, with starvation guard and watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,
    // load/store port
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_mask,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_ack,
    output logic        ls_err,
    // memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    localparam int                   c_TIMER_W    = $clog2(TIMEOUT);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE  = c_TIMER_W'(1);
    localparam logic [3:0]           c_STARVE_MAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_LS = 2'd2
    } state_t;

    state_t               r_state,      w_state_nxt;
    logic [3:0]           r_starve_cnt, w_starve_cnt_nxt;
    logic [c_TIMER_W-1:0] r_timer,      w_timer_nxt;

    logic                 r_mem_we,     w_mem_we_nxt;
    logic [3:0]           r_mem_mask,   w_mem_mask_nxt;
    logic [31:0]          r_mem_addr,   w_mem_addr_nxt;
    logic [31:0]          r_mem_wdata,  w_mem_wdata_nxt;

    logic                 r_if_ack,     w_if_ack_nxt;
    logic                 r_if_err,     w_if_err_nxt;
    logic [31:0]          r_if_rdata,   w_if_rdata_nxt;
    logic                 r_ls_ack,     w_ls_ack_nxt;
    logic                 r_ls_err,     w_ls_err_nxt;
    logic [31:0]          r_ls_rdata,   w_ls_rdata_nxt;

    logic w_busy;
    logic w_if_elig;
    logic w_ls_elig;
    logic w_grant_if;
    logic w_grant_ls;
    logic w_timeout;
    logic w_done;

    // A requester being acked this cycle still holds req; masking it here
    // keeps it from being granted a second, phantom transaction.
    assign w_if_elig  = if_req & ~r_if_ack;
    assign w_ls_elig  = ls_req & ~r_ls_ack;
    assign w_busy     = (r_state != S_IDLE);
    assign w_grant_if = (r_state == S_IDLE) && w_if_elig &&
                        (!w_ls_elig || (r_starve_cnt == c_STARVE_MAX));
    assign w_grant_ls = (r_state == S_IDLE) && w_ls_elig && !w_grant_if;
    assign w_timeout  = (r_timer == c_TIMER_LAST);
    assign w_done     = w_busy && (mem_ack || w_timeout);

    always_comb begin
        w_state_nxt      = r_state;
        w_starve_cnt_nxt = r_starve_cnt;
        w_timer_nxt      = r_timer;
        w_mem_we_nxt     = r_mem_we;
        w_mem_mask_nxt   = r_mem_mask;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_if_ack_nxt     = 1'b0;
        w_if_err_nxt     = 1'b0;
        w_if_rdata_nxt   = r_if_rdata;
        w_ls_ack_nxt     = 1'b0;
        w_ls_err_nxt     = 1'b0;
        w_ls_rdata_nxt   = r_ls_rdata;

        case (r_state)
            S_IDLE: begin
                if (w_grant_if) begin
                    w_state_nxt      = S_BUSY_IF;
                    w_timer_nxt      = '0;
                    w_starve_cnt_nxt = '0;
                    w_mem_we_nxt     = 1'b0;
                    w_mem_mask_nxt   = 4'b0000;
                    w_mem_addr_nxt   = if_addr;
                    w_mem_wdata_nxt  = 32'h0;
                end else if (w_grant_ls) begin
                    w_state_nxt      = S_BUSY_LS;
                    w_timer_nxt      = '0;
                    w_mem_we_nxt     = ls_we;
                    w_mem_mask_nxt   = ls_we ? ls_mask : 4'b0000;
                    w_mem_addr_nxt   = ls_addr;
                    w_mem_wdata_nxt  = ls_wdata;
                    if (w_if_elig && (r_starve_cnt != c_STARVE_MAX)) begin
                        w_starve_cnt_nxt = r_starve_cnt + 4'd1;
                    end
                end
            end

            S_BUSY_IF: begin
                if (w_done) begin
                    // A real ack in the final watchdog cycle beats the timeout.
                    w_state_nxt    = S_IDLE;
                    w_timer_nxt    = '0;
                    w_if_ack_nxt   = 1'b1;
                    w_if_err_nxt   = ~mem_ack;
                    w_if_rdata_nxt = mem_ack ? mem_rdata : 32'h0;
                end else begin
                    w_timer_nxt    = r_timer + c_TIMER_ONE;
                end
            end

            S_BUSY_LS: begin
                if (w_done) begin
                    w_state_nxt    = S_IDLE;
                    w_timer_nxt    = '0;
                    w_ls_ack_nxt   = 1'b1;
                    w_ls_err_nxt   = ~mem_ack;
                    w_ls_rdata_nxt = (mem_ack && !r_mem_we) ? mem_rdata : 32'h0;
                end else begin
                    w_timer_nxt    = r_timer + c_TIMER_ONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_timer      <= '0;
            r_mem_we     <= 1'b0;
            r_mem_mask   <= 4'b0000;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_if_ack     <= 1'b0;
            r_if_err     <= 1'b0;
            r_if_rdata   <= 32'h0;
            r_ls_ack     <= 1'b0;
            r_ls_err     <= 1'b0;
            r_ls_rdata   <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            r_timer      <= w_timer_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_mask   <= w_mem_mask_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_if_ack     <= w_if_ack_nxt;
            r_if_err     <= w_if_err_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_ls_ack     <= w_ls_ack_nxt;
            r_ls_err     <= w_ls_err_nxt;
            r_ls_rdata   <= w_ls_rdata_nxt;
        end
    end

    // mem_req/busy decode straight from state so reset drops them at once.
    assign mem_req   = w_busy;
    assign busy      = w_busy;
    assign mem_we    = r_mem_we;
    assign mem_mask  = r_mem_mask;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ack    = r_if_ack;
    assign if_err    = r_if_err;
    assign if_rdata  = r_if_rdata;
    assign ls_ack    = r_ls_ack;
    assign ls_err    = r_ls_err;
    assign ls_rdata  = r_ls_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_mask;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_ack;
    logic        ls_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .STARVE_MAX (3),
        .TIMEOUT    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_err    (if_err),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_mask   (ls_mask),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_rdata  (ls_rdata),
        .ls_ack    (ls_ack),
        .ls_err    (ls_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_mask  (mem_mask),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_mask = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        chk("rst_mem_req",  mem_req,  0);
        chk("rst_busy",     busy,     0);
        chk("rst_if_ack",   if_ack,   0);
        chk("rst_ls_ack",   ls_ack,   0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        rst_n = 1'b1;
        tick();

        // IFU alone, memory acks one cycle after mem_req rises
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("if1_mem_req",  mem_req,  1);
        chk("if1_mem_addr", mem_addr, 32'h100);
        chk("if1_mem_we",   mem_we,   0);
        chk("if1_if_ack0",  if_ack,   0);
        tick();
        chk("if1_busy", busy, 1);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("if1_if_ack",   if_ack,   1);
        chk("if1_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("if1_if_err",   if_err,   0);
        chk("if1_idle",     busy,     0);
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        chk("if1_no_regrant", busy,     0);
        chk("if1_ack_pulse",  if_ack,   0);
        chk("if1_rdata_hold", if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        tick();

        // Simultaneous requests: LSU store first, then IFU
        if_req = 1'b1; if_addr = 32'h300;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hA5A5A5A5; ls_mask = 4'hF;
        tick();
        chk("pri_busy",      busy,             1);
        chk("pri_mem_we",    mem_we,           1);
        chk("pri_mem_mask",  mem_mask,         4'hF);
        chk("pri_mem_addr",  mem_addr,         32'h200);
        chk("pri_mem_wdata", mem_wdata,        32'hA5A5A5A5);
        chk("pri_starve1",   dut.r_starve_cnt, 1);
        tick(); tick();
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        tick();
        chk("pri_ls_ack",   ls_ack,   1);
        chk("pri_ls_err",   ls_err,   0);
        chk("pri_ls_rdata", ls_rdata, 0);
        chk("pri_if_ack0",  if_ack,   0);
        mem_ack = 1'b0;
        tick();
        chk("pri_if_busy",  busy,             1);
        chk("pri_if_addr",  mem_addr,         32'h300);
        chk("pri_if_we",    mem_we,           0);
        chk("pri_if_mask",  mem_mask,         0);
        chk("pri_starve0",  dut.r_starve_cnt, 0);
        chk("pri_ls_pulse", ls_ack,           0);
        ls_req = 1'b0; ls_we = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        tick();
        chk("pri_if_ack",   if_ack,   1);
        chk("pri_if_rdata", if_rdata, 32'h11112222);
        mem_ack = 1'b0;
        tick();
        if_req = 1'b0;
        tick();

        // Starvation guard: three LSU grants with IFU waiting, then IFU forced
        ls_we = 1'b0; ls_mask = 4'hF; if_addr = 32'h500;
        for (int i = 0; i < 3; i++) begin
            if_req = 1'b1; ls_req = 1'b1; ls_addr = 32'h400 + 32'(i);
            tick();
            chk("stv_busy",   busy,             1);
            chk("stv_addr",   mem_addr,         32'h400 + 32'(i));
            chk("stv_mask",   mem_mask,         0);
            chk("stv_cnt",    dut.r_starve_cnt, 32'(i + 1));
            mem_ack = 1'b1; mem_rdata = 32'h1000 + 32'(i); if_req = 1'b0;
            tick();
            chk("stv_ls_ack", ls_ack,   1);
            chk("stv_rdata",  ls_rdata, 32'h1000 + 32'(i));
            mem_ack = 1'b0;
            tick();
        end
        if_req = 1'b1; ls_req = 1'b1; ls_addr = 32'h410;
        tick();
        chk("stv_if_grant", mem_addr,         32'h500);
        chk("stv_if_we",    mem_we,           0);
        chk("stv_cnt_clr",  dut.r_starve_cnt, 0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
        tick();
        chk("stv_if_ack",   if_ack,   1);
        chk("stv_if_rdata", if_rdata, 32'hCAFE0001);
        chk("stv_ls_ack0",  ls_ack,   0);
        mem_ack = 1'b0;
        tick();
        chk("stv_ls_resume", mem_addr,         32'h410);
        chk("stv_ls_busy",   busy,             1);
        chk("stv_cnt_hold",  dut.r_starve_cnt, 0);
        if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        chk("stv_ls_ack2",  ls_ack,   1);
        chk("stv_ls_rd2",   ls_rdata, 32'h77);
        mem_ack = 1'b0;
        tick();
        chk("stv_idle", busy, 0);
        ls_req = 1'b0;
        tick();

        // Watchdog: LSU load never acked
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h600;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("to_busy", busy, 1);
            tick();
        end
        chk("to_ls_ack",   ls_ack,   1);
        chk("to_ls_err",   ls_err,   1);
        chk("to_ls_rdata", ls_rdata, 0);
        chk("to_idle",     busy,     0);
        ls_we = 1'b1; ls_mask = 4'h3; ls_addr = 32'h604; ls_wdata = 32'h55;
        tick();
        chk("to_ack_pulse", ls_ack, 0);
        chk("to_err_pulse", ls_err, 0);
        tick();
        chk("to_nx_busy", busy,     1);
        chk("to_nx_we",   mem_we,   1);
        chk("to_nx_mask", mem_mask, 4'h3);
        chk("to_nx_addr", mem_addr, 32'h604);
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        chk("to_nx_ack",   ls_ack,   1);
        chk("to_nx_err",   ls_err,   0);
        chk("to_nx_rdata", ls_rdata, 0);
        mem_ack = 1'b0;
        tick();
        ls_req = 1'b0; ls_we = 1'b0;
        tick();

        // mem_ack lands in the last watchdog cycle: the ack wins
        if_req = 1'b1; if_addr = 32'h700;
        tick();
        repeat (15) tick();
        chk("col_timer", dut.r_timer, 15);
        chk("col_busy",  busy,        1);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        chk("col_if_ack",   if_ack,   1);
        chk("col_if_err",   if_err,   0);
        chk("col_if_rdata", if_rdata, 32'h12345678);
        mem_ack = 1'b0;
        tick();
        if_req = 1'b0;
        tick();

        // Asynchronous reset in the middle of an LSU transaction
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h800;
        tick(); tick();
        chk("ar_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_mem_req",  mem_req,  0);
        chk("ar_busy",     busy,     0);
        chk("ar_ls_ack",   ls_ack,   0);
        chk("ar_if_ack",   if_ack,   0);
        chk("ar_mem_addr", mem_addr, 0);
        chk("ar_if_rdata", if_rdata, 0);
        ls_req = 1'b0;
        tick();
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        tick();
        chk("ar_stray_busy",   busy,     0);
        chk("ar_stray_ls_ack", ls_ack,   0);
        chk("ar_stray_if_ack", if_ack,   0);
        chk("ar_stray_rdata",  ls_rdata, 0);
        mem_ack = 1'b0;
        tick();
        chk("ar_quiet_ls", ls_ack, 0);
        chk("ar_quiet_if", if_ack, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
